// File: rtl/seq_alu_if.sv
// Pipeline-facing request/response bundle for the iterative execution ALU.
interface seq_alu_if #(
    parameter int unsigned XLEN = 64
);
    logic            start;
    logic            ready;
    logic [3:0]      alu_funct;
    logic            word_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            zero;

    modport master (
        output start, alu_funct, word_op, operand_a, operand_b,
        input  ready, result, result_valid, zero
    );

    modport slave (
        input  start, alu_funct, word_op, operand_a, operand_b,
        output ready, result, result_valid, zero
    );
endinterface

// File: rtl/seq_alu.sv
// RV64I execution ALU: single-cycle logic/arith/compare, bit-serial shifts,
// start/ready/result_valid handshake and a registered zero flag.
module seq_alu #(
    parameter int unsigned XLEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned WLEN = 32;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_e;

    state_e          state_q, state_d;
    shop_e           shop_q, shop_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;

    logic [2:0]      funct3;
    logic            alt;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_raw;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] fin;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
    endfunction

    assign funct3   = bus.alu_funct[2:0];
    assign alt      = bus.alu_funct[3];
    assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
    assign shamt    = bus.word_op ? SHW'(bus.operand_b[4:0]) : bus.operand_b[SHW-1:0];

    // Single-cycle datapath; shifts only reach here with a zero shift amount.
    always_comb begin
        alu_raw = '0;
        unique case (funct3)
            3'd0: alu_raw = alt ? (bus.operand_a - bus.operand_b)
                                : (bus.operand_a + bus.operand_b);
            3'd2: alu_raw = XLEN'($signed(bus.operand_a) < $signed(bus.operand_b));
            3'd3: alu_raw = XLEN'(bus.operand_a < bus.operand_b);
            3'd4: alu_raw = bus.operand_a ^ bus.operand_b;
            3'd6: alu_raw = bus.operand_a | bus.operand_b;
            3'd7: alu_raw = bus.operand_a & bus.operand_b;
            default: alu_raw = bus.operand_a;
        endcase
    end

    // Word SRA is loaded sign-extended, so the top bit already carries bit 31.
    always_comb begin
        step = shreg_q;
        unique case (shop_q)
            SH_SLL:  step = {shreg_q[XLEN-2:0], 1'b0};
            SH_SRL:  step = {1'b0, shreg_q[XLEN-1:1]};
            SH_SRA:  step = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: step = shreg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shop_d   = shop_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        ready_d  = ready_q;
        fin      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_shift && (shamt != '0)) begin
                        word_d  = bus.word_op;
                        cnt_d   = shamt;
                        shop_d  = (funct3 == 3'd1) ? SH_SLL : (alt ? SH_SRA : SH_SRL);
                        if (!bus.word_op)
                            shreg_d = bus.operand_a;
                        else if (funct3 == 3'd5 && alt)
                            shreg_d = sext_word(bus.operand_a);
                        else
                            shreg_d = zext_word(bus.operand_a);
                        state_d = ST_SHIFT;
                        ready_d = 1'b0;
                    end else begin
                        fin      = bus.word_op ? sext_word(alu_raw) : alu_raw;
                        result_d = fin;
                        zero_d   = (fin == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = step;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    fin      = word_q ? sext_word(step) : step;
                    result_d = fin;
                    zero_d   = (fin == '0);
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                    ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shop_q   <= SH_SLL;
            shreg_q  <= '0;
            cnt_q    <= '0;
            word_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shop_q   <= shop_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.zero         = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-written
// handshake/reset sequences, and random ops against a behavioural model.
module tb_seq_alu;
    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_alu_if #(.XLEN(XLEN)) bus ();

    seq_alu #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  f;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] er;
        int          el;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference semantics straight from the ISA rules.
    function automatic logic [63:0] model_res(input logic [3:0] f, input bit w,
                                              input logic [63:0] a, input logic [63:0] b);
        int          sh;
        logic [31:0] a32;
        logic [63:0] r;
        sh  = w ? int'(b[4:0]) : int'(b[5:0]);
        a32 = a[31:0];
        r   = '0;
        case (f[2:0])
            3'd0: r = f[3] ? a - b : a + b;
            3'd1: r = w ? {32'd0, a32 << sh} : a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: r = (a < b) ? 64'd1 : 64'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (w) r = {32'd0, f[3] ? 32'($signed(a32) >>> sh) : (a32 >> sh)};
                else   r = f[3] ? 64'($signed(a) >>> sh) : (a >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic int model_lat(input logic [3:0] f, input bit w, input logic [63:0] b);
        if (f[2:0] == 3'd1 || f[2:0] == 3'd5) return w ? int'(b[4:0]) : int'(b[5:0]);
        return 0;
    endfunction

    task automatic run_op(input string nm, input logic [3:0] f, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input int el);
        int          lat;
        bit          rdy_bad;
        bit          hold_bad;
        logic [63:0] prev;
        @(negedge clk);
        chk({nm, " ready_idle"}, 64'(bus.ready), 64'd1);
        prev = bus.result;
        bus.alu_funct = f;
        bus.word_op   = w;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.alu_funct = ~f;
        bus.word_op   = ~w;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        lat = 0;
        rdy_bad = 1'b0;
        hold_bad = 1'b0;
        while (!bus.result_valid && lat < 100) begin
            if (bus.ready !== 1'b0) rdy_bad = 1'b1;
            if (bus.result !== prev) hold_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(el));
        chk({nm, " result"}, bus.result, er);
        chk({nm, " zero"}, 64'(bus.zero), 64'(er == 64'd0));
        chk({nm, " ready_low_while_busy"}, 64'(rdy_bad), 64'd0);
        chk({nm, " result_held"}, 64'(hold_bad), 64'd0);
        @(negedge clk);
        chk({nm, " valid_one_cycle"}, 64'(bus.result_valid), 64'd0);
    endtask

    initial begin
        int          nvalid;
        logic [63:0] cap;
        logic [3:0]  rf;
        bit          rw;
        logic [63:0] ra, rb;

        bus.start = 1'b0;
        bus.alu_funct = 4'd0;
        bus.word_op = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;

        vecs.push_back('{"ADD",   4'b0000, 1'b0, 64'd5, 64'd7, 64'd12, 0});
        vecs.push_back('{"SUB",   4'b1000, 1'b0, 64'h1234, 64'h1234, 64'd0, 0});
        vecs.push_back('{"SRA",   4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 4});
        vecs.push_back('{"SRAW",  4'b1101, 1'b1, 64'h0000_0000_8000_0000, 64'd33, 64'hFFFF_FFFF_C000_0000, 1});
        vecs.push_back('{"SLLW",  4'b0001, 1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 31});
        vecs.push_back('{"SLTU",  4'b0011, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0});
        vecs.push_back('{"SLT",   4'b0010, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0});
        vecs.push_back('{"SLL0",  4'b0001, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF, 0});
        vecs.push_back('{"XOR",   4'b0100, 1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF00F_F00F_F00F_F00F, 0});
        vecs.push_back('{"OR",    4'b0110, 1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF0F_FF0F_FF0F_FF0F, 0});
        vecs.push_back('{"AND",   4'b0111, 1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F00_0F00_0F00_0F00, 0});
        vecs.push_back('{"BNE",   4'b1000, 1'b0, 64'h55, 64'h56, 64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{"BLT",   4'b1010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd1, 0});
        vecs.push_back('{"BLTU",  4'b1011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd0, 0});
        vecs.push_back('{"ADDW",  4'b0000, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 0});
        vecs.push_back('{"SRL",   4'b0101, 1'b0, 64'hF0, 64'd4, 64'hF, 4});
        vecs.push_back('{"SRLW",  4'b0101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 31});
        vecs.push_back('{"SRA3",  4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 3});
        vecs.push_back('{"SLL63", 4'b0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h8000_0000_0000_0000, 63});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset ready", 64'(bus.ready), 64'd1);
        chk("reset result", bus.result, 64'd0);
        chk("reset zero", 64'(bus.zero), 64'd1);
        chk("reset valid", 64'(bus.result_valid), 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].el);

        // Back-to-back single-cycle ops: SUB then ADD on consecutive edges.
        @(negedge clk);
        bus.alu_funct = 4'b1000; bus.word_op = 1'b0;
        bus.operand_a = 64'h1234; bus.operand_b = 64'h1234; bus.start = 1'b1;
        @(negedge clk);
        chk("b2b sub valid", 64'(bus.result_valid), 64'd1);
        chk("b2b sub result", bus.result, 64'd0);
        chk("b2b sub zero", 64'(bus.zero), 64'd1);
        chk("b2b ready", 64'(bus.ready), 64'd1);
        bus.alu_funct = 4'b0000; bus.operand_a = 64'd5; bus.operand_b = 64'd7;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b add valid", 64'(bus.result_valid), 64'd1);
        chk("b2b add result", bus.result, 64'd12);
        chk("b2b add zero", 64'(bus.zero), 64'd0);
        @(negedge clk);
        chk("b2b idle valid", 64'(bus.result_valid), 64'd0);

        // Starts during a long shift must be dropped, not queued.
        bus.alu_funct = 4'b0001; bus.operand_a = 64'd1; bus.operand_b = 64'd63; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nvalid = 0;
        cap = '0;
        for (int i = 0; i < 80; i++) begin
            if (bus.result_valid) begin nvalid++; cap = bus.result; end
            bus.start = (i == 5 || i == 20);
            bus.alu_funct = 4'b0000; bus.operand_a = 64'd5; bus.operand_b = 64'd7;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("ignore start valid count", 64'(nvalid), 64'd1);
        chk("ignore start result", cap, 64'h8000_0000_0000_0000);

        // Reset in the middle of a shift aborts it silently.
        bus.alu_funct = 4'b0001; bus.operand_a = 64'd1; bus.operand_b = 64'd63; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", 64'(bus.ready), 64'd1);
        chk("abort result", bus.result, 64'd0);
        chk("abort zero", 64'(bus.zero), 64'd1);
        chk("abort valid", 64'(bus.result_valid), 64'd0);
        nvalid = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.result_valid) nvalid++;
            @(negedge clk);
        end
        chk("abort no late valid", 64'(nvalid), 64'd0);

        // Reset wins over a simultaneous start.
        run_op("pre", 4'b0000, 1'b0, 64'd5, 64'd7, 64'd12, 0);
        bus.alu_funct = 4'b0000; bus.operand_a = 64'd1; bus.operand_b = 64'd2;
        bus.start = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        chk("rst over start valid", 64'(bus.result_valid), 64'd0);
        chk("rst over start result", bus.result, 64'd0);
        @(negedge clk);
        chk("rst over start later valid", 64'(bus.result_valid), 64'd0);

        for (int n = 0; n < 40; n++) begin
            rf = 4'($urandom_range(0, 15));
            rw = 1'($urandom);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 4 == 0) rb = 64'($urandom_range(0, 63));
            run_op($sformatf("rand%0d f=%0h w=%0d", n, rf, rw), rf, rw, ra, rb,
                   model_res(rf, rw, ra, rb), model_lat(rf, rw, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Iterative execution ALU for the RV64I core; it consumes the 4-bit alu_funct code produced by the ALU control decoder.
- Logic/arithmetic/compare ops complete in 1 cycle.
- Shifts run bit-serially, 1 position per cycle.
- Provides a start/ready/result_valid handshake to the pipeline and a zero flag for branch resolution.

Parameters:
- XLEN, 64, operand/result width; shift amount field is log2(XLEN) bits.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted on a rising edge when ready=1
- ready  out  1  high in IDLE; low while shifting
- alu_funct  in  4  operation code
  - [2:0] funct3 encoding: 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND
  - [3] selects SUB (code 0) or SRA (code 5); ignored for other codes
- word_op  in  1  RV64 *W variant (OP_32/OP_IMM_32)
- operand_a  in  XLEN  rs1 / first operand
- operand_b  in  XLEN  rs2 / immediate; shift amount = operand_b[5:0], or operand_b[4:0] when word_op=1
- result  out  XLEN  registered result, held until the next accepted start
- result_valid  out  1  one-cycle pulse; result and zero are valid
- zero  out  1  registered (result == 0)

Behaviour:
- Reset: state IDLE, ready=1, result=0, result_valid=0, zero=1.
  - rst dominates start.
  - rst mid-shift aborts the operation; no result_valid is produced.
- Inputs alu_funct, word_op and operand_a/b are sampled only at the accept edge E0; they may change afterward.
- States: IDLE, SHIFT.
  - IDLE, accept, non-shift op or shamt=0: compute and register result/zero at E0, result_valid=1 during the following cycle, stay IDLE.
  - IDLE, accept, shift with shamt k>0: load the shift register (word_op: sign- or zero-extend operand_a[31:0] per op), count=k, go to SHIFT, ready=0.
  - SHIFT: each edge shifts 1 bit and decrements count.
    - SLL fills 0.
    - SRL fills 0.
    - SRA fills the sign bit: bit XLEN-1, or bit 31 when word_op=1.
  - At the edge where count reaches 0, register result/zero, pulse result_valid, return to IDLE.
- Latency: result_valid rises after edge E_k, where k=0 for non-shifts.
  - Shift by k occupies k+1 cycles.
  - Non-shifts sustain 1 op/cycle back-to-back.
  - A start in the cycle result_valid is high is accepted, since ready=1 there.
- start while ready=0 is ignored and not queued.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare, SLTU unsigned; both give result 0 or 1.
  - XOR/OR/AND are bitwise.
- word_op=1: final result = sign-extension of result[31:0].
  - Applies to every code; only 0, 1 and 5 are architecturally used.
  - Word shifts operate on the 32-bit value, shamt 0..31.
- Branch usage: code 4'b1000 yields zero=1 iff operands are equal; codes 4'b1010 and 4'b1011 yield result[0] = less-than.
- Max shamt 63 means SHIFT lasts 63 cycles; count never wraps.
- result/zero do not change during SHIFT; they hold the previous op's values until the final edge.

Test Plan:
- ADD: alu_funct=4'b0000, a=5, b=7 → result=12, zero=0, result_valid one cycle after accept, ready never drops.
- SUB: alu_funct=4'b1000, a=b=0x1234 → result=0, zero=1; follow with back-to-back ADD on the next cycle to confirm 1/cycle throughput.
- SRA: alu_funct=4'b1101, a=0x8000_0000_0000_0000, b=4 → ready low 4 cycles, result=0xF800_0000_0000_0000 pulse after E4.
- SRAW: word_op=1, alu_funct=4'b1101, a=0x0000_0000_8000_0000, b=33 (shamt=1) → result=0xFFFF_FFFF_C000_0000 after E1.
  - Also SLLW a=0x1, b=31 → 0xFFFF_FFFF_8000_0000.
- Compare: SLTU a=1, b=0xFFFF_FFFF_FFFF_FFFF → 1; SLT with same operands → 0.
  - SLL b=0 → single-cycle completion, result=a.
- Robustness:
  - start pulsed while shifting (SLL a=1, b=63) is ignored; only one result_valid, result=0x8000_0000_0000_0000.
  - rst asserted at cycle 10 of that shift → ready=1, result=0, zero=1, no result_valid.
